// File: rtl/dmd_timing_pkg.sv
// Shared types and default timing for the DMD frame timing generator.
package dmd_timing_pkg;

    localparam int unsigned PIX_W = 24;

    localparam int unsigned DEF_H_ACTIVE = 82;
    localparam int unsigned DEF_H_SYNC   = 4;
    localparam int unsigned DEF_H_BP     = 8;
    localparam int unsigned DEF_H_FP     = 6;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 3;
    localparam int unsigned DEF_V_ACTIVE = 1081;
    localparam int unsigned DEF_V_FP     = 2;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVbp,
        StActive,
        StVfp
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits to hold 0..n-1, never zero-width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmd_frame_timing_gen_if.sv
// Frame trigger in, video timing out, between the fetch stage (master) and the generator (slave).
interface dmd_frame_timing_gen_if;
    import dmd_timing_pkg::*;

    logic             frame_trig;
    logic [PIX_W-1:0] left_offset_in;
    logic             frame_busy;
    logic             trig_dropped;
    logic             h_sync;
    logic             v_sync;
    logic             de;
    logic             de_first_offset_line;
    logic [PIX_W-1:0] display_video_left_offset;

    modport master (
        output frame_trig, left_offset_in,
        input  frame_busy, trig_dropped, h_sync, v_sync, de, de_first_offset_line,
        input  display_video_left_offset
    );

    modport slave (
        input  frame_trig, left_offset_in,
        output frame_busy, trig_dropped, h_sync, v_sync, de, de_first_offset_line,
        output display_video_left_offset
    );

endinterface

// File: rtl/dmd_line_counter.sv
// Pixel/line counters with wrap, line-end strobe and next-value outputs for registered decode.
module dmd_line_counter #(
    parameter int unsigned H_TOTAL = 100,
    parameter int unsigned HW      = 7,
    parameter int unsigned VW      = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          h_run,
    input  logic          h_clear,
    input  logic          v_clear,
    output logic [VW-1:0] v_cnt,
    output logic [HW-1:0] h_nxt,
    output logic [VW-1:0] v_nxt,
    output logic          line_end
);

    localparam logic [HW-1:0] HLast = HW'(H_TOTAL - 1);

    logic [HW-1:0] h_cnt;

    always_comb begin
        line_end = h_run && (h_cnt == HLast);

        h_nxt = h_cnt;
        if (h_clear || line_end) begin
            h_nxt = '0;
        end else if (h_run) begin
            h_nxt = h_cnt + 1'b1;
        end

        v_nxt = v_cnt;
        if (v_clear) begin
            v_nxt = '0;
        end else if (line_end) begin
            v_nxt = v_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

endmodule

// File: rtl/dmd_frame_timing_gen.sv
// DMD frame timing generator: one frame of h_sync/v_sync/de per accepted frame_trig.
// DMD_TIMING_IDLE_HSYNC_EN keeps h_cnt and h_sync free-running while idle.
module dmd_frame_timing_gen
    import dmd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP
) (
    input logic                   clk,
    input logic                   rst,
    dmd_frame_timing_gen_if.slave bus
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_MAX   = max2(max2(V_SYNC, V_BP), max2(V_ACTIVE, V_FP));
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_MAX);

    localparam logic [HW-1:0] HSyncEnd   = HW'(H_SYNC);
    localparam logic [HW-1:0] DeStart    = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] DeEnd      = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] VSyncLast  = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] VBpLast    = VW'(V_BP - 1);
    localparam logic [VW-1:0] VActLast   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VFpLast    = VW'(V_FP - 1);

    state_e state_q, state_d;

    logic          h_run, h_clear, v_clear, line_end, accept;
    logic [VW-1:0] v_cnt, v_nxt;
    logic [HW-1:0] h_nxt;

    logic             busy_d, hs_d, vs_d, de_d, fol_d;
    logic             busy_q, hs_q, vs_q, de_q, fol_q, dropped_q;
    logic [PIX_W-1:0] offset_d, offset_q;

    dmd_line_counter #(
        .H_TOTAL (H_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_line_counter (
        .clk      (clk),
        .rst      (rst),
        .h_run    (h_run),
        .h_clear  (h_clear),
        .v_clear  (v_clear),
        .v_cnt    (v_cnt),
        .h_nxt    (h_nxt),
        .v_nxt    (v_nxt),
        .line_end (line_end)
    );

    always_comb begin
        state_d = state_q;
        h_run   = 1'b1;
        h_clear = 1'b0;
        v_clear = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                v_clear = 1'b1;
`ifdef DMD_TIMING_IDLE_HSYNC_EN
                h_run   = 1'b1;
`else
                h_run   = 1'b0;
                h_clear = 1'b1;
`endif
                if (bus.frame_trig) begin
                    accept  = 1'b1;
                    h_clear = 1'b1;
                    state_d = StVsync;
                end
            end
            StVsync: if (line_end && v_cnt == VSyncLast) begin
                state_d = StVbp;
                v_clear = 1'b1;
            end
            StVbp: if (line_end && v_cnt == VBpLast) begin
                state_d = StActive;
                v_clear = 1'b1;
            end
            StActive: if (line_end && v_cnt == VActLast) begin
                state_d = StVfp;
                v_clear = 1'b1;
            end
            StVfp: if (line_end && v_cnt == VFpLast) begin
                state_d = StIdle;
                v_clear = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Decode from next-state values so registered outputs line up with the counters.
    always_comb begin
        busy_d   = (state_d != StIdle);
`ifdef DMD_TIMING_IDLE_HSYNC_EN
        hs_d     = (h_nxt < HSyncEnd);
`else
        hs_d     = busy_d && (h_nxt < HSyncEnd);
`endif
        vs_d     = (state_d == StVsync);
        de_d     = (state_d == StActive) && (h_nxt >= DeStart) && (h_nxt < DeEnd);
        fol_d    = (state_d == StActive) && (v_nxt == '0);
        offset_d = accept ? bus.left_offset_in : offset_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            fol_q     <= 1'b0;
            dropped_q <= 1'b0;
            offset_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            fol_q     <= fol_d;
            dropped_q <= dropped_q | (bus.frame_trig && state_q != StIdle);
            offset_q  <= offset_d;
        end
    end

    assign bus.frame_busy                = busy_q;
    assign bus.trig_dropped              = dropped_q;
    assign bus.h_sync                    = hs_q;
    assign bus.v_sync                    = vs_q;
    assign bus.de                        = de_q;
    assign bus.de_first_offset_line      = fol_q;
    assign bus.display_video_left_offset = offset_q;

endmodule
